aud_i2s_master: RTL and testbench
=================================

# aud_i2s_master

I2S bus master emulating the WM8731 codec side of the audio link. It generates BCLK, ADCLRCK and DACLRCK. It serializes stereo ADC samples onto ADCDAT, which is the transmitter for the recorder's I2S receiver, and it deserializes DACDAT from the player. It sits in the audio subsystem as a synthesizable codec stand-in, so recorder/player/DSP can run on-chip without the WM8731 attached.

## Interface
- DATA_W, 16, sample width in bits
- SLOT_W, 32, BCLK periods per channel slot; must be ≥ DATA_W+1
- BCLK_DIV, 2, i_clk cycles per BCLK half-period; must be ≥ 1
- Clocking (already decided): one clock; reset is asynchronous and active-low.
- i_clk  in  1  system clock
- i_rst_n  in  1  async active-low reset
- i_en  in  1  run request; sampled only at frame boundaries
- i_adc_valid  in  1  stereo pair offered
- o_adc_ready  out  1  pair buffer empty
- i_adc_left  in  DATA_W  left sample
- i_adc_right  in  DATA_W  right sample
- o_underrun  out  1  one-cycle pulse: frame started with empty buffer
- o_bclk  out  1  bit clock
- o_adclrck  out  1  ADC word select: 0 = left, 1 = right
- o_daclrck  out  1  DAC word select; identical to o_adclrck
- o_adcdat  out  1  serial ADC data, MSB first
- i_dacdat  in  1  serial DAC data from player
- o_dac_sample  out  DATA_W  last captured DAC word
- o_dac_right  out  1  channel of o_dac_sample
- o_dac_valid  out  1  one-cycle pulse: o_dac_sample updated

## Operation
- Reset values: o_bclk, o_adclrck, o_daclrck, o_adcdat, o_underrun, o_dac_valid, o_dac_right = 0; o_dac_sample = 0; o_adc_ready = 1; buffer empty; state IDLE.
- Clock generator: div_cnt counts 0..BCLK_DIV-1. At the terminal count, o_bclk toggles. A "fall event" is a toggle 1→0 (or the first IDLE→RUN step); a "rise event" is a toggle 0→1.
- Frame counter bit_cnt runs 0..2·SLOT_W-1 and advances on each fall event. The slot index is k = bit_cnt mod SLOT_W. LRCK = (bit_cnt ≥ SLOT_W) and updates on the fall event.
- FSM states: IDLE, RUN.
  - IDLE: o_bclk held 0, counters cleared. i_en=1 enters RUN, and that cycle counts as the fall event with bit_cnt=0.
  - RUN: at the fall event that wraps bit_cnt 2·SLOT_W-1→0, if i_en=0 go to IDLE. The frame in progress always completes.
- ADC buffer:
  - One stereo-pair register. The pair is accepted on i_adc_valid & o_adc_ready; o_adc_ready then drops next cycle.
  - At each frame start (bit_cnt=0 fall event), a full buffer loads into the L/R shift registers and empties. An empty buffer loads zeros and pulses o_underrun.
  - Acceptance in the same cycle as frame start: the frame load takes the old contents (or zeros) first, and the new pair stays buffered.
- ADC serialization: on the fall event with k in 1..DATA_W, o_adcdat = sample[DATA_W-k] of the current channel. Otherwise o_adcdat = 0. This places the MSB one BCLK after the LRCK edge (I2S).
- DAC capture: on the rise event with k in 1..DATA_W, i_dacdat shifts in MSB first. At the k=DATA_W rise event, the word lands in o_dac_sample and o_dac_right = current LRCK. o_dac_valid pulses the following cycle.
- Reset mid-frame: all state returns to reset values immediately, and the partial DAC word is discarded.

## Timing
- BCLK period = 2·BCLK_DIV i_clk. Frame = 2·SLOT_W BCLK periods, which is 256 i_clk at defaults.
- All outputs are registered. o_adcdat and LRCK change in the same cycle as the o_bclk falling edge.
- IDLE→RUN: o_bclk first rises BCLK_DIV cycles after the cycle i_en is sampled high.
- o_dac_valid is 1 cycle after the capturing rise event.
- o_adc_ready re-asserts 1 cycle after the frame-start load.

## Structure
- Shared package aud_pkg holds the channel enum (CH_LEFT=0, CH_RIGHT=1) and the I2S state enum (IDLE, RUN). These are shared with the recorder/player.
- One sub-module, aud_bclk_gen, contains div_cnt, o_bclk, and the rise/fall event strobes.

## Test plan
- Reset, then i_en=1 with pair L=0xA5C3, R=0x3C5A preloaded and a bench I2S receiver attached → receiver decodes 0xA5C3 left, 0x3C5A right. The ADCDAT MSB appears on the second BCLK rise after each LRCK edge.
- Feed 0x8001 L / 0x7FFE R on i_dacdat at I2S timing → o_dac_valid pulses twice per frame, giving 0x8001 with o_dac_right=0, then 0x7FFE with o_dac_right=1.
- Leave the buffer empty across a frame start → o_underrun pulses exactly once and ADCDAT is all zeros for that frame. A pair supplied later is sent in the next frame.
- Drop i_en at bit_cnt=10 → the frame finishes through bit_cnt=63, then o_bclk stays 0 and LRCK=0. Re-asserting i_en restarts at bit_cnt=0.
- Offer a pair in the exact frame-start cycle → the old pair is transmitted, the new pair is transmitted in the next frame, and no pair is lost.
- Assert i_rst_n=0 mid-word → all outputs return to reset values within the same cycle and no o_dac_valid follows. After release, BCLK_DIV=1 gives a BCLK period of 2 i_clk.

Source files
------------

// File: rtl/aud_pkg.sv
// Shared audio-subsystem types: channel select and I2S link state.
// Used by the codec stand-in as well as the recorder and player.
package aud_pkg;

   // Channel carried by a word, matching the LRCK level.
   typedef enum logic {
      CH_LEFT  = 1'b0,
      CH_RIGHT = 1'b1
   } aud_ch_e;

   // I2S link state.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } i2s_state_e;

   // Maps an LRCK level onto the channel enum.
   function automatic aud_ch_e ch_of_lrck(input logic lrck);
      return lrck ? CH_RIGHT : CH_LEFT;
   endfunction

endpackage

// File: rtl/aud_bclk_gen.sv
// Bit-clock generator: divides clk down to BCLK and flags the cycles in
// which BCLK is about to rise or fall. The start strobe counts as a fall
// event so the first frame begins from the IDLE->RUN step.
module aud_bclk_gen
   import aud_pkg::*;
#(
   parameter int BCLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic run,
   output logic bclk,
   output logic rise,
   output logic fall
);

   localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   logic [DIV_W-1:0] div_cnt_reg;
   logic             bclk_reg;
   logic             term;

   assign term = (div_cnt_reg == DIV_LAST);
   assign rise = run & term & ~bclk_reg;
   assign fall = start | (run & term & bclk_reg);
   assign bclk = bclk_reg;

   // Divider and BCLK toggle; both held cleared outside RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_reg <= '0;
         bclk_reg    <= 1'b0;
      end else if (run) begin
         if (term) begin
            div_cnt_reg <= '0;
            bclk_reg    <= ~bclk_reg;
         end else begin
            div_cnt_reg <= div_cnt_reg + DIV_ONE;
         end
      end else begin
         div_cnt_reg <= '0;
         bclk_reg    <= 1'b0;
      end
   end

endmodule

// File: rtl/aud_i2s_master.sv
// I2S master standing in for the WM8731 codec: drives BCLK and both LRCKs,
// serializes buffered stereo ADC pairs onto ADCDAT and captures DACDAT.
module aud_i2s_master
   import aud_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int SLOT_W   = 32,
   parameter int BCLK_DIV = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_adc_valid,
   output logic              o_adc_ready,
   input  logic [DATA_W-1:0] i_adc_left,
   input  logic [DATA_W-1:0] i_adc_right,
   output logic              o_underrun,
   output logic              o_bclk,
   output logic              o_adclrck,
   output logic              o_daclrck,
   output logic              o_adcdat,
   input  logic              i_dacdat,
   output logic [DATA_W-1:0] o_dac_sample,
   output logic              o_dac_right,
   output logic              o_dac_valid
);

   localparam int FRAME = 2 * SLOT_W;
   localparam int CNT_W = $clog2(FRAME);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] SLOT_LEN  = CNT_W'(SLOT_W);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W);

   i2s_state_e        state_reg, state_next;
   logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
   logic              lrck_reg, lrck_next;
   logic [CNT_W-1:0]  k_cur, k_next;
   logic              start, run, rise, fall, wrap, stop, frame_start;
   logic              accept;
   logic              ready_reg;
   logic [DATA_W-1:0] buf_l_reg, buf_r_reg;
   logic [DATA_W-1:0] sh_l_reg, sh_r_reg;
   logic              adcdat_reg, underrun_reg;
   logic [DATA_W-1:0] dac_sh_reg, dac_word, dac_sample_reg;
   aud_ch_e           dac_ch_reg;
   logic              dac_valid_reg;
   logic              dac_bit, dac_last;

   assign run   = (state_reg == RUN);
   assign start = (state_reg == IDLE) & i_en;

   aud_bclk_gen #(
      .BCLK_DIV(BCLK_DIV)
   ) u_bclk_gen (
      .clk  (i_clk),
      .rst_n(i_rst_n),
      .start(start),
      .run  (run),
      .bclk (o_bclk),
      .rise (rise),
      .fall (fall)
   );

   // A wrapping fall event either starts the next frame or, with i_en low,
   // ends the link; the frame in progress always completes first.
   assign wrap        = run & fall & (bit_cnt_reg == CNT_LAST);
   assign stop        = wrap & ~i_en;
   assign frame_start = start | (wrap & i_en);

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   // Next-state logic: enable is only honoured at frame boundaries.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (i_en) state_next = RUN;
         RUN:     if (stop) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Frame position after the coming fall event, plus its slot index.
   always_comb begin
      bit_cnt_next = bit_cnt_reg;
      if (start || wrap) bit_cnt_next = '0;
      else if (fall)     bit_cnt_next = bit_cnt_reg + CNT_ONE;
      lrck_next = (bit_cnt_next >= SLOT_LEN);
      k_next    = lrck_next ? (bit_cnt_next - SLOT_LEN) : bit_cnt_next;
      k_cur     = lrck_reg  ? (bit_cnt_reg  - SLOT_LEN) : bit_cnt_reg;
   end

   // Frame counter and word select advance together on fall events.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bit_cnt_reg <= '0;
         lrck_reg    <= 1'b0;
      end else if (fall) begin
         bit_cnt_reg <= bit_cnt_next;
         lrck_reg    <= lrck_next;
      end
   end

   assign accept = i_adc_valid & ready_reg;

   // Single-pair buffer; the frame load sees the contents before any
   // same-cycle acceptance, so a pair arriving then waits for next frame.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ready_reg    <= 1'b1;
         buf_l_reg    <= '0;
         buf_r_reg    <= '0;
         underrun_reg <= 1'b0;
      end else begin
         underrun_reg <= frame_start & ready_reg;
         if (accept) begin
            buf_l_reg <= i_adc_left;
            buf_r_reg <= i_adc_right;
            ready_reg <= 1'b0;
         end else if (frame_start && !ready_reg) begin
            ready_reg <= 1'b1;
         end
      end
   end

   // ADC serializer: MSB goes out one BCLK after the LRCK edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sh_l_reg   <= '0;
         sh_r_reg   <= '0;
         adcdat_reg <= 1'b0;
      end else if (fall) begin
         if (frame_start) begin
            sh_l_reg   <= ready_reg ? '0 : buf_l_reg;
            sh_r_reg   <= ready_reg ? '0 : buf_r_reg;
            adcdat_reg <= 1'b0;
         end else if (k_next >= CNT_ONE && k_next <= DATA_LAST) begin
            if (lrck_next) begin
               adcdat_reg <= sh_r_reg[DATA_W-1];
               sh_r_reg   <= {sh_r_reg[DATA_W-2:0], 1'b0};
            end else begin
               adcdat_reg <= sh_l_reg[DATA_W-1];
               sh_l_reg   <= {sh_l_reg[DATA_W-2:0], 1'b0};
            end
         end else begin
            adcdat_reg <= 1'b0;
         end
      end
   end

   assign dac_bit  = rise & (k_cur >= CNT_ONE) & (k_cur <= DATA_LAST);
   assign dac_last = rise & (k_cur == DATA_LAST);
   assign dac_word = {dac_sh_reg[DATA_W-2:0], i_dacdat};

   // DAC deserializer: shifts on rise events, publishes the full word.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         dac_sh_reg     <= '0;
         dac_sample_reg <= '0;
         dac_ch_reg     <= CH_LEFT;
         dac_valid_reg  <= 1'b0;
      end else begin
         dac_valid_reg <= dac_last;
         if (dac_bit) dac_sh_reg <= dac_word;
         if (dac_last) begin
            dac_sample_reg <= dac_word;
            dac_ch_reg     <= ch_of_lrck(lrck_reg);
         end
      end
   end

   assign o_adc_ready  = ready_reg;
   assign o_underrun   = underrun_reg;
   assign o_adclrck    = lrck_reg;
   assign o_daclrck    = lrck_reg;
   assign o_adcdat     = adcdat_reg;
   assign o_dac_sample = dac_sample_reg;
   assign o_dac_right  = (dac_ch_reg == CH_RIGHT);
   assign o_dac_valid  = dac_valid_reg;

endmodule

// File: tb/tb_aud_i2s_master.sv
// Bench for aud_i2s_master: a bench-side I2S receiver/player on the serial
// pins, expected words queued at stimulus time and compared on arrival.
module tb_aud_i2s_master;

   localparam int DATA_W = 16;
   localparam int SLOT_W = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic              adc_valid = 1'b0;
   logic [DATA_W-1:0] adc_left = '0;
   logic [DATA_W-1:0] adc_right = '0;
   logic              dacdat = 1'b0;
   logic              adc_ready, underrun, bclk, adclrck, daclrck, adcdat;
   logic [DATA_W-1:0] dac_sample;
   logic              dac_right, dac_valid;

   logic              en1 = 1'b0;
   logic              adc_ready1, underrun1, bclk1, adclrck1, daclrck1, adcdat1;
   logic [DATA_W-1:0] dac_sample1;
   logic              dac_right1, dac_valid1;

   int assert_cnt = 0;
   int fail_cnt = 0;

   logic [DATA_W:0] rx_q[$];
   logic [DATA_W:0] dac_q[$];
   logic [DATA_W:0] exp_q[$];
   logic [DATA_W:0] exp_dac_q[$];

   logic              prev_bclk = 1'b0;
   logic              last_lrck = 1'b1;
   int                mon_k = 0;
   int                idle = 0;
   int                rise_total = 0;
   int                underrun_cnt = 0;
   int                dac_valid_cnt = 0;
   logic [DATA_W-1:0] rx_sh = '0;
   logic [DATA_W-1:0] tx_l = '0;
   logic [DATA_W-1:0] tx_r = '0;

   always #5 clk = ~clk;

   aud_i2s_master #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(2)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
      .i_adc_valid(adc_valid), .o_adc_ready(adc_ready),
      .i_adc_left(adc_left), .i_adc_right(adc_right),
      .o_underrun(underrun), .o_bclk(bclk), .o_adclrck(adclrck),
      .o_daclrck(daclrck), .o_adcdat(adcdat), .i_dacdat(dacdat),
      .o_dac_sample(dac_sample), .o_dac_right(dac_right), .o_dac_valid(dac_valid)
   );

   aud_i2s_master #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en1),
      .i_adc_valid(1'b0), .o_adc_ready(adc_ready1),
      .i_adc_left(16'h0000), .i_adc_right(16'h0000),
      .o_underrun(underrun1), .o_bclk(bclk1), .o_adclrck(adclrck1),
      .o_daclrck(daclrck1), .o_adcdat(adcdat1), .i_dacdat(1'b0),
      .o_dac_sample(dac_sample1), .o_dac_right(dac_right1), .o_dac_valid(dac_valid1)
   );

   // Bench I2S receiver and player: counts BCLK rises since each LRCK edge
   // (or since the link went idle), decodes ADCDAT, drives DACDAT.
   initial begin
      int nk;
      logic [DATA_W-1:0] word;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_bclk = 1'b0;
            last_lrck = 1'b1;
            mon_k = 0;
            idle = 0;
            dacdat = 1'b0;
         end else begin
            if (bclk && !prev_bclk) begin
               rise_total++;
               if (adclrck != last_lrck) mon_k = 0;
               else mon_k++;
               last_lrck = adclrck;
               if (mon_k >= 1 && mon_k <= DATA_W) begin
                  rx_sh = {rx_sh[DATA_W-2:0], adcdat};
                  if (mon_k == DATA_W) rx_q.push_back({adclrck, rx_sh});
               end
               nk = (mon_k == SLOT_W - 1) ? 0 : mon_k + 1;
               word = adclrck ? tx_r : tx_l;
               dacdat = (nk >= 1 && nk <= DATA_W) ? word[DATA_W-nk] : 1'b0;
            end
            prev_bclk = bclk;
            if (bclk) idle = 0;
            else if (idle < 100) idle++;
            if (idle > 8) last_lrck = 1'b1;
            if (dac_valid) begin
               dac_q.push_back({dac_right, dac_sample});
               dac_valid_cnt++;
            end
            if (underrun) underrun_cnt++;
         end
      end
   end

   task automatic do_reset();
      en = 1'b0;
      en1 = 1'b0;
      adc_valid = 1'b0;
      tx_l = '0;
      tx_r = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rx_q.delete();
      dac_q.delete();
      exp_q.delete();
      exp_dac_q.delete();
      rise_total = 0;
      underrun_cnt = 0;
      dac_valid_cnt = 0;
   endtask

   // Holds a pair valid until a clock edge sees it accepted.
   task automatic offer_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                             output bit ok);
      adc_left = l;
      adc_right = r;
      adc_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         ok = adc_ready;
         @(negedge clk);
      end
      adc_valid = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int budget);
      for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [24:0] got;
      rst_n = 1'b0;
      en = 1'b1;
      repeat (2) @(negedge clk);
      got = {bclk, adclrck, daclrck, adcdat, underrun, dac_valid, dac_right, dac_sample, adc_ready};
      assert_cnt++;
      if (got !== {7'b0, 16'h0000, 1'b1, 1'b0} >> 1) begin
         fail_cnt++;
         $display("FAIL reset_outputs: got %h expected %h", got, 25'h1);
      end else $display("reset_outputs %h", got);
      assert_cnt++;
      if (bclk1 !== 1'b0 || adc_ready1 !== 1'b1) begin
         fail_cnt++;
         $display("FAIL reset_div1: got bclk=%b ready=%b expected bclk=0 ready=1", bclk1, adc_ready1);
      end
      en = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_adc_tx();
      bit ok;
      logic [DATA_W:0] e, g;
      do_reset();
      offer_pair(16'hA5C3, 16'h3C5A, ok);
      assert_cnt++;
      if (!ok) begin fail_cnt++; $display("FAIL adc_accept: got timeout expected accept"); end
      assert_cnt++;
      if (adc_ready !== 1'b0) begin fail_cnt++; $display("FAIL ready_drop: got %b expected 0", adc_ready); end
      exp_q.push_back({1'b0, 16'hA5C3});
      exp_q.push_back({1'b1, 16'h3C5A});
      en = 1'b1;
      @(negedge clk);
      assert_cnt++;
      if (adc_ready !== 1'b1 || bclk !== 1'b0) begin
         fail_cnt++;
         $display("FAIL start_load: got ready=%b bclk=%b expected ready=1 bclk=0", adc_ready, bclk);
      end
      @(negedge clk);
      assert_cnt++;
      if (bclk !== 1'b0) begin fail_cnt++; $display("FAIL bclk_first_low: got %b expected 0", bclk); end
      @(negedge clk);
      assert_cnt++;
      if (bclk !== 1'b1) begin fail_cnt++; $display("FAIL bclk_first_rise: got %b expected 1", bclk); end
      en = 1'b0;
      wait_rx(2, 600);
      wait_cycles(300);
      assert_cnt++;
      if (rx_q.size() != exp_q.size()) begin
         fail_cnt++;
         $display("FAIL adc_count: got %0d expected %0d", rx_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         e = exp_q.pop_front();
         g = rx_q.pop_front();
         assert_cnt++;
         if (g !== e) begin fail_cnt++; $display("FAIL adc_word: got %h expected %h", g, e); end
         else $display("adc_word ch=%0d data=%h", g[DATA_W], g[DATA_W-1:0]);
      end
      assert_cnt++;
      if (underrun_cnt != 0) begin fail_cnt++; $display("FAIL adc_no_underrun: got %0d expected 0", underrun_cnt); end
   endtask

   task automatic test_dac_rx();
      logic [DATA_W:0] e, g;
      do_reset();
      tx_l = 16'h8001;
      tx_r = 16'h7FFE;
      exp_dac_q.push_back({1'b0, 16'h8001});
      exp_dac_q.push_back({1'b1, 16'h7FFE});
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      for (int i = 0; i < 600 && dac_q.size() < 2; i++) @(negedge clk);
      wait_cycles(300);
      assert_cnt++;
      if (dac_valid_cnt != 2) begin fail_cnt++; $display("FAIL dac_valid_count: got %0d expected 2", dac_valid_cnt); end
      while (exp_dac_q.size() > 0 && dac_q.size() > 0) begin
         e = exp_dac_q.pop_front();
         g = dac_q.pop_front();
         assert_cnt++;
         if (g !== e) begin fail_cnt++; $display("FAIL dac_word: got %h expected %h", g, e); end
         else $display("dac_word right=%0d data=%h", g[DATA_W], g[DATA_W-1:0]);
      end
   endtask

   task automatic test_underrun();
      bit ok;
      logic [DATA_W:0] e, g;
      do_reset();
      exp_q.push_back({1'b0, 16'h0000});
      exp_q.push_back({1'b1, 16'h0000});
      en = 1'b1;
      for (int i = 0; i < 200 && rise_total < 20; i++) @(negedge clk);
      offer_pair(16'h1234, 16'h5678, ok);
      assert_cnt++;
      if (!ok) begin fail_cnt++; $display("FAIL underrun_accept: got timeout expected accept"); end
      exp_q.push_back({1'b0, 16'h1234});
      exp_q.push_back({1'b1, 16'h5678});
      wait_rx(4, 1200);
      en = 1'b0;
      wait_cycles(300);
      assert_cnt++;
      if (underrun_cnt != 1) begin fail_cnt++; $display("FAIL underrun_pulses: got %0d expected 1", underrun_cnt); end
      assert_cnt++;
      if (rx_q.size() != exp_q.size()) begin
         fail_cnt++;
         $display("FAIL underrun_count: got %0d expected %0d", rx_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         e = exp_q.pop_front();
         g = rx_q.pop_front();
         assert_cnt++;
         if (g !== e) begin fail_cnt++; $display("FAIL underrun_word: got %h expected %h", g, e); end
         else $display("underrun_word ch=%0d data=%h", g[DATA_W], g[DATA_W-1:0]);
      end
   endtask

   task automatic test_stop_restart();
      bit ok;
      logic [DATA_W:0] e, g;
      do_reset();
      offer_pair(16'h1111, 16'h2222, ok);
      exp_q.push_back({1'b0, 16'h1111});
      exp_q.push_back({1'b1, 16'h2222});
      en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (mon_k == 10 && rise_total > 10) break;
      end
      en = 1'b0;
      wait_cycles(400);
      assert_cnt++;
      if (rise_total != 2 * SLOT_W) begin fail_cnt++; $display("FAIL stop_rises: got %0d expected %0d", rise_total, 2 * SLOT_W); end
      assert_cnt++;
      if (bclk !== 1'b0 || adclrck !== 1'b0 || daclrck !== 1'b0) begin
         fail_cnt++;
         $display("FAIL stop_idle: got bclk=%b lrck=%b expected 0 0", bclk, adclrck);
      end
      offer_pair(16'h3333, 16'h4444, ok);
      exp_q.push_back({1'b0, 16'h3333});
      exp_q.push_back({1'b1, 16'h4444});
      en = 1'b1;
      wait_rx(4, 600);
      en = 1'b0;
      wait_cycles(300);
      assert_cnt++;
      if (rx_q.size() != exp_q.size()) begin
         fail_cnt++;
         $display("FAIL stop_count: got %0d expected %0d", rx_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         e = exp_q.pop_front();
         g = rx_q.pop_front();
         assert_cnt++;
         if (g !== e) begin fail_cnt++; $display("FAIL stop_word: got %h expected %h", g, e); end
         else $display("stop_word ch=%0d data=%h", g[DATA_W], g[DATA_W-1:0]);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [DATA_W:0] e, g;
      // Buffer full at frame start: offered pair waits one frame.
      do_reset();
      offer_pair(16'hAAAA, 16'h5555, ok);
      exp_q.push_back({1'b0, 16'hAAAA});
      exp_q.push_back({1'b1, 16'h5555});
      en = 1'b1;
      offer_pair(16'h0F0F, 16'hF0F0, ok);
      exp_q.push_back({1'b0, 16'h0F0F});
      exp_q.push_back({1'b1, 16'hF0F0});
      exp_q.push_back({1'b0, 16'h0000});
      exp_q.push_back({1'b1, 16'h0000});
      wait_rx(6, 1800);
      en = 1'b0;
      wait_cycles(300);
      assert_cnt++;
      if (underrun_cnt != 1) begin fail_cnt++; $display("FAIL b2b_underrun: got %0d expected 1", underrun_cnt); end
      assert_cnt++;
      if (rx_q.size() != exp_q.size()) begin
         fail_cnt++;
         $display("FAIL b2b_count: got %0d expected %0d", rx_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         e = exp_q.pop_front();
         g = rx_q.pop_front();
         assert_cnt++;
         if (g !== e) begin fail_cnt++; $display("FAIL b2b_word: got %h expected %h", g, e); end
         else $display("b2b_word ch=%0d data=%h", g[DATA_W], g[DATA_W-1:0]);
      end
      // Buffer empty, pair accepted in the frame-start cycle itself.
      do_reset();
      exp_q.push_back({1'b0, 16'h0000});
      exp_q.push_back({1'b1, 16'h0000});
      exp_q.push_back({1'b0, 16'hC001});
      exp_q.push_back({1'b1, 16'h300C});
      en = 1'b1;
      offer_pair(16'hC001, 16'h300C, ok);
      wait_rx(4, 1200);
      en = 1'b0;
      wait_cycles(300);
      assert_cnt++;
      if (underrun_cnt != 1) begin fail_cnt++; $display("FAIL same_cycle_underrun: got %0d expected 1", underrun_cnt); end
      assert_cnt++;
      if (rx_q.size() != exp_q.size()) begin
         fail_cnt++;
         $display("FAIL same_cycle_count: got %0d expected %0d", rx_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         e = exp_q.pop_front();
         g = rx_q.pop_front();
         assert_cnt++;
         if (g !== e) begin fail_cnt++; $display("FAIL same_cycle_word: got %h expected %h", g, e); end
         else $display("same_cycle_word ch=%0d data=%h", g[DATA_W], g[DATA_W-1:0]);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [24:0] got;
      int rises[3];
      int nr;
      logic prev;
      do_reset();
      tx_l = 16'hFFFF;
      tx_r = 16'hFFFF;
      offer_pair(16'hBEEF, 16'hCAFE, ok);
      en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (mon_k == 8 && rise_total > 8) break;
      end
      rst_n = 1'b0;
      #1;
      got = {bclk, adclrck, daclrck, adcdat, underrun, dac_valid, dac_right, dac_sample, adc_ready};
      assert_cnt++;
      if (got !== 25'h1) begin fail_cnt++; $display("FAIL midreset_outputs: got %h expected %h", got, 25'h1); end
      else $display("midreset_outputs %h", got);
      en = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      dac_valid_cnt = 0;
      wait_cycles(300);
      assert_cnt++;
      if (dac_valid_cnt != 0 || dac_sample !== 16'h0000) begin
         fail_cnt++;
         $display("FAIL midreset_no_dac: got valids=%0d sample=%h expected 0 0000", dac_valid_cnt, dac_sample);
      end
      en1 = 1'b1;
      nr = 0;
      prev = 1'b0;
      for (int c = 1; c <= 40 && nr < 3; c++) begin
         @(negedge clk);
         if (bclk1 && !prev) begin
            rises[nr] = c;
            nr++;
         end
         prev = bclk1;
      end
      en1 = 1'b0;
      assert_cnt++;
      if (nr != 3) begin
         fail_cnt++;
         $display("FAIL div1_rises: got %0d expected 3", nr);
      end else begin
         $display("div1_rises at %0d %0d %0d", rises[0], rises[1], rises[2]);
         assert_cnt++;
         if (rises[0] != 2) begin fail_cnt++; $display("FAIL div1_first_rise: got %0d expected 2", rises[0]); end
         assert_cnt++;
         if (rises[1] - rises[0] != 2 || rises[2] - rises[1] != 2) begin
            fail_cnt++;
            $display("FAIL div1_period: got %0d %0d expected 2 2", rises[1] - rises[0], rises[2] - rises[1]);
         end
      end
      wait_cycles(200);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_adc_tx();
      test_dac_rx();
      test_underrun();
      test_stop_restart();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
